// File: rtl/fp_mult_collect_if.sv
// Handshake and status bundle between the multiplier collection stage and its
// operand source / result consumer.
interface fp_mult_collect_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          op_valid;
  logic          op_ready;
  logic [31:0]   z_in;
  logic [7:0]    status_in;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_z;
  logic [7:0]    res_status;
  logic [CW-1:0] count;
  logic [5:0]    flags;
  logic          flags_clr;
  logic [5:0]    irq_mask;
  logic          irq;

  modport master (
    output op_valid, z_in, status_in, res_ready, flags_clr, irq_mask,
    input  op_ready, res_valid, res_z, res_status, count, flags, irq
  );

  modport slave (
    input  op_valid, z_in, status_in, res_ready, flags_clr, irq_mask,
    output op_ready, res_valid, res_z, res_status, count, flags, irq
  );
endinterface

// File: rtl/fp_mult_collect.sv
// Collects multiplier results at a fixed latency into a credit-protected FIFO
// with sticky exception flags. Define FP_MULT_COLLECT_IRQ_EN to enable irq.
module fp_mult_collect #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic           clk,
  input logic           rst,
  fp_mult_collect_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count;
  logic [5:0]     flags_q, flags_d;
  logic           irq_q, irq_d;
  logic [37:0]    mem_q [DEPTH];
  logic [37:0]    head;
  logic           op_fire, cap, pop, res_valid;
  int unsigned    inflight;

  // Credits come from registered state only, so res_ready never reaches op_ready.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path can infer a latch.
    inflight = 0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + {31'b0, vpipe_q[i]};
    end
  end

  assign count     = wr_ptr_q - rd_ptr_q;
  assign res_valid = (count != '0);
  assign op_fire   = bus.op_valid & bus.op_ready;
  assign cap       = vpipe_q[LAT-1];
  assign pop       = res_valid & bus.res_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.op_ready   = (32'(count) + inflight) < 32'(DEPTH);
  assign bus.res_valid  = res_valid;
  assign bus.res_z      = res_valid ? head[31:0] : '0;
  assign bus.res_status = res_valid ? {2'b00, head[37:32]} : '0;
  assign bus.count      = count;
  assign bus.flags      = flags_q;
  assign bus.irq        = irq_q;

  always_comb begin
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = op_fire;
    wr_ptr_d   = cap ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // A clear coinciding with a capture keeps the newly captured bits.
    flags_d    = (bus.flags_clr ? 6'b0 : flags_q) | (cap ? bus.status_in[5:0] : 6'b0);
`ifdef FP_MULT_COLLECT_IRQ_EN
    irq_d      = |(flags_d & bus.irq_mask);
`else
    irq_d      = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      vpipe_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      vpipe_q  <= vpipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are visible, so a reset port here only costs logic.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.status_in[5:0], bus.z_in};
    end
  end
endmodule
